// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants, slot operation codes and helpers for the pipe_stage_reg pipeline stage.
// The optional statistics counters are enabled with the PIPE_STAGE_STATS_EN macro.
package pipe_stage_reg_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned EXC_W_DEF  = 5;

  // Equivalents of `Exc_None and `Exc_Handler_PC from the legacy constants file
  localparam logic [4:0]  EXC_NONE_DEF   = 5'd0;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  typedef enum logic [2:0] {
    SLOT_HOLD,
    SLOT_LOAD,
    SLOT_BUBBLE,
    SLOT_CLEAR,
    SLOT_REDIRECT
  } slot_op_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One {valid, pc, data, exc, bd} storage slot of the pipeline stage.
// The stage instantiates it twice: once for the main slot and once for the skid slot.
module pipe_stage_reg_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned          DATA_W     = DATA_W_DEF,
  parameter int unsigned          PC_W       = PC_W_DEF,
  parameter int unsigned          EXC_W      = EXC_W_DEF,
  parameter logic [EXC_W-1:0]     EXC_NONE   = EXC_W'(EXC_NONE_DEF),
  parameter logic [PC_W-1:0]      HANDLER_PC = PC_W'(HANDLER_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  slot_op_e          op_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [EXC_W-1:0]  exc_i,
  input  logic              bd_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic [EXC_W-1:0]  exc_o,
  output logic              bd_o
);

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q,    pc_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [EXC_W-1:0]  exc_q,   exc_d;
  logic              bd_q,    bd_d;

  // A clear only drops valid, so the payload stays visible on the outputs
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    data_d  = data_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    case (op_i)
      SLOT_LOAD: begin
        valid_d = 1'b1;
        pc_d    = pc_i;
        data_d  = data_i;
        exc_d   = exc_i;
        bd_d    = bd_i;
      end
      SLOT_BUBBLE: begin
        valid_d = 1'b1;
        pc_d    = pc_i;
        data_d  = '0;
        exc_d   = EXC_NONE;
        bd_d    = 1'b0;
      end
      SLOT_CLEAR: begin
        valid_d = 1'b0;
      end
      SLOT_REDIRECT: begin
        valid_d = 1'b0;
        pc_d    = HANDLER_PC;
        data_d  = '0;
        exc_d   = EXC_NONE;
        bd_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      data_q  <= '0;
      exc_q   <= EXC_NONE;
      bd_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign data_o  = data_q;
  assign exc_o   = exc_q;
  assign bd_o    = bd_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic MIPS pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAGE_STATS_EN to build the saturating stall/bubble statistics counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned          DATA_W     = DATA_W_DEF,
  parameter int unsigned          PC_W       = PC_W_DEF,
  parameter int unsigned          EXC_W      = EXC_W_DEF,
  parameter logic [EXC_W-1:0]     EXC_NONE   = EXC_W'(EXC_NONE_DEF),
  parameter logic [PC_W-1:0]      HANDLER_PC = PC_W'(HANDLER_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic [15:0]       stat_stall,
  output logic [15:0]       stat_bubble
);

  logic              skidValid;
  logic [PC_W-1:0]   skidPc;
  logic [DATA_W-1:0] skidData;
  logic [EXC_W-1:0]  skidExc;
  logic              skidBd;

  logic              accept, drain;
  slot_op_e          mainOp, skidOp, entryOp;
  logic [PC_W-1:0]   mainPcIn;
  logic [DATA_W-1:0] mainDataIn;
  logic [EXC_W-1:0]  mainExcIn;
  logic              mainBdIn;

  // in_ready comes straight from the skid flop, so stall never ripples upstream combinationally
  assign in_ready = ~skidValid;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;
  assign entryOp  = flush ? SLOT_BUBBLE : SLOT_LOAD;

  always_comb begin
    mainOp = SLOT_HOLD;
    skidOp = SLOT_HOLD;
    if (Req) begin
      mainOp = SLOT_REDIRECT;
      skidOp = SLOT_CLEAR;
    end else if (skidValid) begin
      if (drain) begin
        mainOp = SLOT_LOAD;
        skidOp = SLOT_CLEAR;
      end
    end else if (!out_valid || drain) begin
      if (accept) begin
        mainOp = entryOp;
      end else if (drain) begin
        mainOp = SLOT_CLEAR;
      end
    end else if (accept) begin
      skidOp = entryOp;
    end
  end

  // A full skid slot always refills main first; otherwise main takes the upstream entry
  always_comb begin
    mainPcIn   = in_pc;
    mainDataIn = in_data;
    mainExcIn  = in_exc;
    mainBdIn   = in_bd;
    if (skidValid) begin
      mainPcIn   = skidPc;
      mainDataIn = skidData;
      mainExcIn  = skidExc;
      mainBdIn   = skidBd;
    end
  end

  pipe_stage_reg_slot #(
    .DATA_W    (DATA_W),
    .PC_W      (PC_W),
    .EXC_W     (EXC_W),
    .EXC_NONE  (EXC_NONE),
    .HANDLER_PC(HANDLER_PC)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .op_i   (mainOp),
    .pc_i   (mainPcIn),
    .data_i (mainDataIn),
    .exc_i  (mainExcIn),
    .bd_i   (mainBdIn),
    .valid_o(out_valid),
    .pc_o   (out_pc),
    .data_o (out_data),
    .exc_o  (out_exc),
    .bd_o   (out_bd)
  );

  pipe_stage_reg_slot #(
    .DATA_W    (DATA_W),
    .PC_W      (PC_W),
    .EXC_W     (EXC_W),
    .EXC_NONE  (EXC_NONE),
    .HANDLER_PC(HANDLER_PC)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .op_i   (skidOp),
    .pc_i   (in_pc),
    .data_i (in_data),
    .exc_i  (in_exc),
    .bd_i   (in_bd),
    .valid_o(skidValid),
    .pc_o   (skidPc),
    .data_o (skidData),
    .exc_o  (skidExc),
    .bd_o   (skidBd)
  );

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] statStall_q, statStall_d;
  logic [15:0] statBubble_q, statBubble_d;

  // Req discards the accept, so a flush in the same cycle produces no bubble
  always_comb begin
    statStall_d  = statStall_q;
    statBubble_d = statBubble_q;
    if (out_valid && !out_ready) statStall_d = sat_inc16(statStall_q);
    if (accept && flush && !Req) statBubble_d = sat_inc16(statBubble_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      statStall_q  <= '0;
      statBubble_q <= '0;
    end else begin
      statStall_q  <= statStall_d;
      statBubble_q <= statBubble_d;
    end
  end

  assign stat_stall  = statStall_q;
  assign stat_bubble = statBubble_q;
`else
  assign stat_stall  = '0;
  assign stat_bubble = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
// Stats expectations follow PIPE_STAGE_STATS_EN when the bench is compiled with it.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, Req, flush, in_valid, in_ready, in_bd;
  logic [31:0] in_pc, in_data;
  logic [4:0]  in_exc;
  logic        out_valid, out_ready, out_bd;
  logic [31:0] out_pc, out_data;
  logic [4:0]  out_exc;
  logic [15:0] stat_stall, stat_bubble;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  exc;
    logic        bd;
  } entry_t;

  entry_t      fifoModel[$];
  entry_t      shown;
  logic [15:0] mStall, mBubble;
  bit          statsOn;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk        (clk),
    .reset      (reset),
    .Req        (Req),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_data    (in_data),
    .in_exc     (in_exc),
    .in_bd      (in_bd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_data   (out_data),
    .out_exc    (out_exc),
    .out_bd     (out_bd),
    .stat_stall (stat_stall),
    .stat_bubble(stat_bubble)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] pc, input logic [31:0] data,
                               input logic [4:0] exc, input bit bd, input bit fl,
                               input bit rq, input bit ordy);
    in_valid  = v;
    in_pc     = pc;
    in_data   = data;
    in_exc    = exc;
    in_bd     = bd;
    flush     = fl;
    Req       = rq;
    out_ready = ordy;
  endtask

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  // Stage seen as a 2-deep FIFO: front is shown; when empty the last shown payload lingers
  task automatic modelStep();
    bit     acc, drn;
    entry_t e;
    acc = in_valid && (fifoModel.size() < 2);
    drn = (fifoModel.size() > 0) && out_ready;
    if (reset) begin
      fifoModel.delete();
      shown   = '0;
      mStall  = '0;
      mBubble = '0;
    end else begin
      if (fifoModel.size() > 0 && !out_ready) mStall = satInc(mStall);
      if (Req) begin
        fifoModel.delete();
        shown = entry_t'{pc: 32'h0000_4180, data: 32'h0, exc: 5'd0, bd: 1'b0};
      end else begin
        if (acc && flush) mBubble = satInc(mBubble);
        if (drn) shown = fifoModel.pop_front();
        if (acc) begin
          if (flush) e = entry_t'{pc: in_pc, data: 32'h0, exc: 5'd0, bd: 1'b0};
          else       e = entry_t'{pc: in_pc, data: in_data, exc: in_exc, bd: in_bd};
          fifoModel.push_back(e);
        end
        if (fifoModel.size() > 0) shown = fifoModel[0];
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("out_valid", 64'(out_valid), 64'(fifoModel.size() > 0));
    checkOutput("in_ready", 64'(in_ready), 64'(fifoModel.size() < 2));
    checkOutput("out_pc", 64'(out_pc), 64'(shown.pc));
    checkOutput("out_data", 64'(out_data), 64'(shown.data));
    checkOutput("out_exc", 64'(out_exc), 64'(shown.exc));
    checkOutput("out_bd", 64'(out_bd), 64'(shown.bd));
    checkOutput("stat_stall", 64'(stat_stall), statsOn ? 64'(mStall) : 64'h0);
    checkOutput("stat_bubble", 64'(stat_bubble), statsOn ? 64'(mBubble) : 64'h0);
  endtask

  task automatic tick(input bit doCheck);
    @(posedge clk);
    modelStep();
    #1;
    if (doCheck) compareAll();
  endtask

  initial begin
`ifdef PIPE_STAGE_STATS_EN
    statsOn = 1'b1;
`else
    statsOn = 1'b0;
`endif
    shown = '0; mStall = '0; mBubble = '0;
    applyStimulus(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1);
    reset = 1'b1;
    tick(1);
    tick(1);
    checkOutput("reset_valid", 64'(out_valid), 64'h0);
    checkOutput("reset_pc", 64'(out_pc), 64'h0);
    checkOutput("reset_ready", 64'(in_ready), 64'h1);
    reset = 1'b0;

    // streaming at full rate
    applyStimulus(1, 32'h3000, 32'h11, 5'd0, 0, 0, 0, 1); tick(1);
    checkOutput("stream_pc0", 64'(out_pc), 64'h3000);
    applyStimulus(1, 32'h3004, 32'h22, 5'd0, 1, 0, 0, 1); tick(1);
    checkOutput("stream_pc1", 64'(out_pc), 64'h3004);
    applyStimulus(1, 32'h3008, 32'h33, 5'd2, 0, 0, 0, 1); tick(1);
    checkOutput("stream_pc2", 64'(out_pc), 64'h3008);
    checkOutput("stream_valid", 64'(out_valid), 64'h1);
    applyStimulus(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1); tick(1);

    // backpressure fills the skid slot
    applyStimulus(1, 32'h3000, 32'hA0, 5'd0, 0, 0, 0, 0); tick(1);
    applyStimulus(1, 32'h3004, 32'hA4, 5'd0, 0, 0, 0, 0); tick(1);
    checkOutput("bp_ready_low", 64'(in_ready), 64'h0);
    applyStimulus(1, 32'h3008, 32'hA8, 5'd0, 0, 0, 0, 0); tick(1);
    checkOutput("bp_hold_pc", 64'(out_pc), 64'h3000);
    applyStimulus(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1); tick(1);
    checkOutput("bp_second_pc", 64'(out_pc), 64'h3004);
    checkOutput("bp_ready_high", 64'(in_ready), 64'h1);
    tick(1);
    checkOutput("bp_empty", 64'(out_valid), 64'h0);

    // flush converts the accepted entry into a bubble
    applyStimulus(1, 32'h3010, 32'h8C01_0004, 5'd4, 1, 1, 0, 1); tick(1);
    checkOutput("flush_pc", 64'(out_pc), 64'h3010);
    checkOutput("flush_data", 64'(out_data), 64'h0);
    checkOutput("flush_exc", 64'(out_exc), 64'h0);
    checkOutput("flush_valid", 64'(out_valid), 64'h1);
    checkOutput("flush_stat", 64'(stat_bubble), statsOn ? 64'h1 : 64'h0);
    applyStimulus(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1); tick(1);

    // Req kills both stored entries and the same-cycle accept
    applyStimulus(1, 32'h5000, 32'h1, 5'd0, 0, 0, 0, 0); tick(1);
    applyStimulus(1, 32'h5004, 32'h2, 5'd0, 0, 0, 0, 0); tick(1);
    applyStimulus(1, 32'h5008, 32'h3, 5'd0, 0, 0, 1, 0); tick(1);
    checkOutput("req_valid", 64'(out_valid), 64'h0);
    checkOutput("req_pc", 64'(out_pc), 64'h4180);
    checkOutput("req_ready", 64'(in_ready), 64'h1);
    applyStimulus(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, $urandom, $urandom, 5'($urandom_range(0, 31)),
                    1'($urandom), $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 55);
      reset = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    reset = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
    reset = 1'b1;
    applyStimulus(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0); tick(1);
    reset = 1'b0;
    applyStimulus(1, 32'h6000, 32'h6, 5'd0, 0, 0, 0, 0); tick(1);
    applyStimulus(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) tick(0);
    tick(1);
    checkOutput("stall_saturated", 64'(stat_stall), 64'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
